// File: rtl/led_switch_pio.sv
`default_nettype none
// ============================================================================
// Module   : led_switch_pio
// Brief    : Avalon-MM LED/switch PIO: debounced switches with edge capture,
//            masked level IRQ, optional LED blink engine (LED_SWITCH_PIO_BLINK_EN).
// Revision : 1.0
// ============================================================================
module led_switch_pio #(
    parameter int LED_W      = 8,
    parameter int SW_W       = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             irq,
    output logic [LED_W-1:0] led_array_io_export,
    input  logic [SW_W-1:0]  switch_array_io_export
);

    localparam int                 c_cnt_w      = $clog2(DEB_CYCLES);
    localparam logic [c_cnt_w-1:0] c_deb_max    = c_cnt_w'(DEB_CYCLES - 1);
    localparam logic [2:0]         c_addr_led   = 3'd0;
    localparam logic [2:0]         c_addr_state = 3'd3;
    localparam logic [2:0]         c_addr_edge  = 3'd4;
    localparam logic [2:0]         c_addr_mask  = 3'd5;

    logic [LED_W-1:0] r_led_data;
    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sync1;
    logic [SW_W-1:0]  r_sync2;
    logic [SW_W-1:0]  r_sw_state;
    logic [SW_W-1:0]  r_sw_edge;
    logic [SW_W-1:0]  r_irq_mask;
    logic             r_irq;
    logic [31:0]      r_readdata;
    logic             r_rdv;

    logic [SW_W-1:0]  w_fire;
    logic [SW_W-1:0]  w_edge_clr;
    logic [LED_W-1:0] w_led_next;
    logic [31:0]      w_rd_mux;
    logic             w_wr_led;
    logic             w_wr_edge;
    logic             w_wr_mask;
    logic             w_unused;

    assign w_wr_led   = avs_write && (avs_address == c_addr_led);
    assign w_wr_edge  = avs_write && (avs_address == c_addr_edge);
    assign w_wr_mask  = avs_write && (avs_address == c_addr_mask);
    assign w_edge_clr = w_wr_edge ? avs_writedata[SW_W-1:0] : '0;
    assign w_unused   = ^avs_writedata;

    // Per-bit debounce: a bit must disagree with SW_STATE for DEB_CYCLES cycles.
    for (genvar gi = 0; gi < SW_W; gi++) begin : g_deb
        logic [c_cnt_w-1:0] r_cnt;
        logic               w_diff;

        assign w_diff     = r_sync2[gi] ^ r_sw_state[gi];
        assign w_fire[gi] = w_diff && (r_cnt == c_deb_max);

        always_ff @(posedge clk_clk) begin
            if (!reset_reset_n || !w_diff || w_fire[gi]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef LED_SWITCH_PIO_BLINK_EN
    localparam logic [2:0] c_addr_blink = 3'd1;
    localparam logic [2:0] c_addr_div   = 3'd2;

    logic [LED_W-1:0] r_led_blink;
    logic [23:0]      r_blink_div;
    logic [23:0]      r_blink_cnt;
    logic             r_phase;
    logic             w_wr_blink;
    logic             w_wr_div;

    assign w_wr_blink = avs_write && (avs_address == c_addr_blink);
    assign w_wr_div   = avs_write && (avs_address == c_addr_div);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_led_blink <= '0;
            r_blink_div <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            if (w_wr_blink) begin
                r_led_blink <= avs_writedata[LED_W-1:0];
            end
            // A divider write restarts the blink period from phase 0.
            if (w_wr_div) begin
                r_blink_div <= avs_writedata[23:0];
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_blink_div == '0) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_blink_cnt == r_blink_div - 24'd1) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 24'd1;
            end
        end
    end

    assign w_led_next = r_led_data & ~(r_led_blink & {LED_W{r_phase}});
`else
    assign w_led_next = r_led_data;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            c_addr_led:   w_rd_mux[LED_W-1:0] = r_led_data;
`ifdef LED_SWITCH_PIO_BLINK_EN
            c_addr_blink: w_rd_mux[LED_W-1:0] = r_led_blink;
            c_addr_div:   w_rd_mux[23:0]      = r_blink_div;
`endif
            c_addr_state: w_rd_mux[SW_W-1:0]  = r_sw_state;
            c_addr_edge:  w_rd_mux[SW_W-1:0]  = r_sw_edge;
            c_addr_mask:  w_rd_mux[SW_W-1:0]  = r_irq_mask;
            default:      w_rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_led_data <= '0;
            r_led      <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sw_state <= '0;
            r_sw_edge  <= '0;
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
            r_rdv      <= 1'b0;
        end else begin
            r_sync1    <= switch_array_io_export;
            r_sync2    <= r_sync1;
            if (w_wr_led) begin
                r_led_data <= avs_writedata[LED_W-1:0];
            end
            if (w_wr_mask) begin
                r_irq_mask <= avs_writedata[SW_W-1:0];
            end
            r_sw_state <= r_sw_state ^ w_fire;
            // A new edge wins over a simultaneous write-1-to-clear.
            r_sw_edge  <= (r_sw_edge & ~w_edge_clr) | w_fire;
            r_irq      <= |(r_sw_edge & r_irq_mask);
            r_led      <= w_led_next;
            r_rdv      <= avs_read;
            r_readdata <= avs_read ? w_rd_mux : '0;
        end
    end

    assign avs_readdata        = r_readdata;
    assign avs_readdatavalid   = r_rdv;
    assign irq                 = r_irq;
    assign led_array_io_export = r_led;

endmodule
`default_nettype wire

// File: tb/tb_led_switch_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_switch_pio
// Brief    : Self-checking bench for led_switch_pio (register table + sequences).
// Revision : 1.0
// ============================================================================
module tb_led_switch_pio;

    localparam int LED_W = 8;
    localparam int SW_W  = 4;
    localparam int DEB   = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       avs_address;
    logic             avs_read;
    logic             avs_write;
    logic [31:0]      avs_writedata;
    logic [31:0]      avs_readdata;
    logic             avs_readdatavalid;
    logic             irq;
    logic [LED_W-1:0] led;
    logic [SW_W-1:0]  sw;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    led_switch_pio #(
        .LED_W      (LED_W),
        .SW_W       (SW_W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk_clk                (clk),
        .reset_reset_n          (reset_n),
        .avs_address            (avs_address),
        .avs_read               (avs_read),
        .avs_write              (avs_write),
        .avs_writedata          (avs_writedata),
        .avs_readdata           (avs_readdata),
        .avs_readdatavalid      (avs_readdatavalid),
        .irq                    (irq),
        .led_array_io_export    (led),
        .switch_array_io_export (sw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
        avs_writedata = '0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        chk({name, "_valid"}, {31'b0, avs_readdatavalid}, 32'h1);
        chk(name, avs_readdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'd0, 32'h1234_5678, 32'h0000_0078};
        vecs[1] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[2] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_000F};
        vecs[3] = '{3'd5, 32'h0000_0001, 32'h0000_0001};
        vecs[4] = '{3'd3, 32'h0000_000F, 32'h0000_0000};
        vecs[5] = '{3'd4, 32'h0000_000F, 32'h0000_0000};
        vecs[6] = '{3'd6, 32'h0000_1234, 32'h0000_0000};
        vecs[7] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
`ifdef LED_SWITCH_PIO_BLINK_EN
        vecs[8] = '{3'd1, 32'h0000_0F0F, 32'h0000_000F};
        vecs[9] = '{3'd2, 32'hFF34_5678, 32'h0034_5678};
`else
        vecs[8] = '{3'd1, 32'h0000_0F0F, 32'h0000_0000};
        vecs[9] = '{3'd2, 32'hFF34_5678, 32'h0000_0000};
`endif

        // Reset, with a read strobe held to prove it is suppressed
        reset_n = 1'b0; avs_address = '0; avs_read = 1'b1; avs_write = 1'b0;
        avs_writedata = '0; sw = '0;
        ticks(3);
        chk("rst_led",   {24'b0, led}, 32'h0);
        chk("rst_irq",   {31'b0, irq}, 32'h0);
        chk("rst_rdv",   {31'b0, avs_readdatavalid}, 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        avs_read = 1'b0; reset_n = 1'b1;
        tick();
        rd_chk("rst_sw_state", 3'd3, 32'h0);

        // LED write: output appears two edges after the strobe
        wr(3'd0, 32'hA5);
        chk("led_lag", {24'b0, led}, 32'h0);
        tick();
        chk("led_a5", {24'b0, led}, 32'hA5);
        rd_chk("rd_led_a5", 3'd0, 32'hA5);
        tick();
        chk("rdv_idle",   {31'b0, avs_readdatavalid}, 32'h0);
        chk("rdata_idle", avs_readdata, 32'h0);

        // Register table
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd_chk($sformatf("tbl_rd[%0d]", i), vecs[i].addr, vecs[i].exp);
        end
        tick();
        chk("led_after_tbl", {24'b0, led}, 32'hFF);
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h0);

        // Simultaneous read and write returns the old value
        avs_address = 3'd0; avs_writedata = 32'h3C; avs_write = 1'b1; avs_read = 1'b1;
        tick();
        avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
        chk("rw_rdv", {31'b0, avs_readdatavalid}, 32'h1);
        chk("rw_old", avs_readdata, 32'hFF);
        rd_chk("rw_new", 3'd0, 32'h3C);
        wr(3'd0, 32'hFF);

        // Debounce: a short pulse is rejected
        wr(3'd5, 32'h1);
        sw = 4'h1; ticks(10); sw = 4'h0; ticks(30);
        chk("pulse_irq", {31'b0, irq}, 32'h0);
        rd_chk("pulse_state", 3'd3, 32'h0);
        rd_chk("pulse_edge",  3'd4, 32'h0);

        // Held high: state/edge at edge 2+DEB, irq one edge later
        sw = 4'h1;
        ticks(2 + DEB);
        chk("deb_irq_pre", {31'b0, irq}, 32'h0);
        tick();
        chk("deb_irq_rise", {31'b0, irq}, 32'h1);
        rd_chk("deb_state", 3'd3, 32'h1);
        rd_chk("deb_edge",  3'd4, 32'h1);

        // Write-1-to-clear drops irq two edges after the strobe
        wr(3'd4, 32'h1);
        chk("clr_irq_lag", {31'b0, irq}, 32'h1);
        tick();
        chk("clr_irq_low", {31'b0, irq}, 32'h0);
        rd_chk("clr_edge", 3'd4, 32'h0);

        // Falling edge also captured
        sw = 4'h0;
        ticks(2 + DEB + 2);
        chk("fall_irq", {31'b0, irq}, 32'h1);
        rd_chk("fall_state", 3'd3, 32'h0);

        // Clear on the same edge as a new edge: bit stays set
        sw = 4'h1;
        ticks(2 + DEB - 1);
        wr(3'd4, 32'h1);
        chk("coin_irq0", {31'b0, irq}, 32'h1);
        tick();
        chk("coin_irq1", {31'b0, irq}, 32'h1);
        rd_chk("coin_edge",  3'd4, 32'h1);
        rd_chk("coin_state", 3'd3, 32'h1);

        // Masking the bit drops irq one edge after the mask write
        wr(3'd5, 32'h0);
        chk("mask_lag", {31'b0, irq}, 32'h1);
        tick();
        chk("mask_off", {31'b0, irq}, 32'h0);

`ifdef LED_SWITCH_PIO_BLINK_EN
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'h4);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("blink[%0d]", k), {24'b0, led},
                (((k - 1) / 4) % 2 == 1) ? 32'hF0 : 32'hFF);
        end
        wr(3'd2, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("blink_div0[%0d]", k), {24'b0, led}, 32'hFF);
        end
        wr(3'd2, 32'h2);
`else
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'h4);
        rd_chk("noblink_rd1", 3'd1, 32'h0);
        rd_chk("noblink_rd2", 3'd2, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("noblink_led[%0d]", k), {24'b0, led}, 32'hFF);
        end
`endif

        // Reset mid-blink and mid-debounce of bit1
        wr(3'd5, 32'h1);
        tick();
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        sw = 4'h3;
        ticks(7);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_led", {24'b0, led}, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_rdv", {31'b0, avs_readdatavalid}, 32'h0);
        reset_n = 1'b1;
        rd_chk("post_rst_state", 3'd3, 32'h0);
        rd_chk("post_rst_edge",  3'd4, 32'h0);
        rd_chk("post_rst_mask",  3'd5, 32'h0);
        rd_chk("post_rst_led",   3'd0, 32'h0);
        chk("post_rst_leds", {24'b0, led}, 32'h0);

        // Held switches re-qualify after reset and raise edges
        ticks(20);
        rd_chk("requal_state", 3'd3, 32'h3);
        rd_chk("requal_edge",  3'd4, 32'h3);
        chk("requal_irq", {31'b0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
